ddr3_avl_arbiter: RTL and testbench
===================================

# ddr3_avl_arbiter

Two-master arbiter for the single DDR3 Avalon-MM port in `ddr3_control`. Master 0 is the display read engine (reads only) and master 1 is the frame write engine (writes only). The block grants the port to one master at a time and holds the grant for a whole command: one read request, or every beat of a write burst. It also tracks outstanding read beats so the display path can be monitored.

## Interface
- `ADDR_W`, 26, Avalon word address width.
- `DATA_W`, 128, data width.
- `STARVE_LIMIT`, 16, maximum consecutive read grants while a write is pending; used only in priority mode.

- `ddr3_clk`  in  1  clock.
- `ddr3_reset_n`  in  1  asynchronous, active-low reset.
- `m0_burstbegin`, `m0_read_req`  in  1  read master request; held until `m0_ready`.
- `m0_addr`  in  ADDR_W  read address.
- `m0_size`  in  3  read burst length in beats.
- `m0_ready`  out  1  read command accepted this cycle.
- `m0_read_data_valid`  out  1  read data valid, passed through from `avl_read_data_valid`.
- `m0_read_data`  out  DATA_W  read data, passed through from `avl_read_data`.
- `m1_burstbegin`, `m1_write_req`  in  1  write master request.
- `m1_addr`  in  ADDR_W  write address.
- `m1_size`  in  3  write burst length in beats.
- `m1_wdata`  in  DATA_W  write data.
- `m1_be`  in  DATA_W/8  write byte enables.
- `m1_ready`  out  1  write beat accepted this cycle.
- `avl_ready`  in  1  controller ready.
- `avl_burstbegin`, `avl_read_req`, `avl_write_req`  out  1  controller command strobes.
- `avl_addr`  out  ADDR_W  controller address.
- `avl_size`  out  3  controller burst size.
- `avl_wdata`  out  DATA_W  controller write data.
- `avl_be`  out  DATA_W/8  controller byte enables.
- `avl_read_data_valid`  in  1  controller read data valid.
- `avl_read_data`  in  DATA_W  controller read data.
- `rd_outstanding`  out  8  read beats requested but not yet returned.

## Operation
- States are IDLE, GRANT_RD and GRANT_WR, held in a registered grant register.
- Output muxing is combinational from the grant.
  - In GRANT_RD, `avl_*` carry the `m0_*` fields, `avl_write_req`=0, and `m0_ready`=`avl_ready`.
  - In GRANT_WR, `avl_*` carry the `m1_*` fields, `avl_read_req`=0, and `m1_ready`=`avl_ready`.
  - In IDLE, all `avl_*` outputs and both ready outputs are 0.
- IDLE transitions:
  - Only `m0_read_req` asserted: go to GRANT_RD.
  - Only `m1_write_req` asserted: go to GRANT_WR.
  - Both asserted: arbitration decides (see Configuration).
- GRANT_RD returns to IDLE on the cycle where `avl_ready & m0_read_req` is true.
- GRANT_WR beat counting:
  - `m1_size` is latched into a 3-bit beat counter on the first accepted beat, which must carry `m1_burstbegin`.
  - The counter decrements on each accepted beat (`avl_ready & m1_write_req`).
  - The grant returns to IDLE on the accepted beat that brings the count to 0.
  - `m1_size`=0 is treated as 1 beat.
- A single master is never granted twice back-to-back without passing through IDLE.
- `rd_outstanding` counter:
  - Adds `m0_size` on an accepted read (0 counts as 1).
  - Subtracts 1 per `avl_read_data_valid`.
  - When both occur in the same cycle, it applies `+size-1`.
  - It saturates at 255 and does not go below 0.
- Read data is never gated by the grant. Returns arriving during a write grant still reach master 0.

## Timing
- Reset values (asynchronous, taking effect mid-burst too):
  - State = IDLE.
  - All `avl_*` outputs = 0.
  - `m0_ready` = `m1_ready` = 0.
  - `rd_outstanding` = 0.
  - Starvation counter = 0.
  - Round-robin pointer = master 0 is next.
  - Masters must reissue any in-flight command after reset.
- Grant latency: a request seen in IDLE at cycle N drives `avl_*` from cycle N+1.
- Accept latency: 0 cycles from `avl_ready` to `mX_ready`.
- Each read command occupies 1 grant cycle plus 1 IDLE cycle, with any number of `avl_ready`=0 stall cycles inserted in between.
- Each write burst occupies `size` accepted beats plus stall cycles plus 1 IDLE cycle.
- A master dropping its request mid-grant holds the grant; it is not aborted. The master must reassert its request to finish the command.

## Configuration
- Macro `DDR3_ARB_RD_PRIORITY_EN`.
- Defined (read priority):
  - On contention master 0 wins.
  - A counter increments on each read grant issued while `m1_write_req` is asserted.
  - When the counter reaches `STARVE_LIMIT`, the next contention goes to master 1.
  - The counter clears on any write grant.
- Undefined (round-robin):
  - On contention the master not granted last wins.
  - The pointer updates on every grant.
  - `STARVE_LIMIT` is ignored.

## Test plan
- Single read: `m0_size`=4, address 0x100, `avl_ready` low for 3 cycles, then high.
  - `avl_read_req` rises 1 cycle after the request and holds through the stall.
  - `m0_ready` pulses once.
  - `rd_outstanding` = 4, then drops to 0 after 4 valid beats.
- Write burst: `m1_size`=3 with `avl_ready` toggling.
  - Exactly 3 `m1_ready` pulses.
  - `avl_burstbegin` only on the first beat.
  - Back to IDLE after beat 3.
- Contention, macro undefined: both masters request continuously.
  - Grants alternate RD, WR, RD, WR with one IDLE cycle between each.
- Contention, macro defined, `STARVE_LIMIT`=16: both masters request continuously.
  - 16 read grants, then 1 write grant, then reads resume.
- Overlap: read data returns (4 beats) during a `m1_size`=4 write.
  - All 4 beats appear on `m0_read_data_valid`.
  - `rd_outstanding` reaches 0.
  - No write beat is lost.
- Reset mid-write after beat 1 of 4.
  - Outputs go to 0 immediately.
  - After release the arbiter idles until a new request arrives.

Source files
------------

// File: rtl/ddr3_avl_arbiter.sv
// rtl/ddr3_avl_arbiter.sv - two-master arbiter for the single DDR3 Avalon-MM port
// Contention policy: round-robin by default; read priority with write starvation guard when DDR3_ARB_RD_PRIORITY_EN is defined.
module ddr3_avl_arbiter #(
  parameter int ADDR_W       = 26,
  parameter int DATA_W       = 128,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                ddr3_clk,
  input  logic                ddr3_reset_n,
  input  logic                m0_burstbegin,
  input  logic                m0_read_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [2:0]          m0_size,
  output logic                m0_ready,
  output logic                m0_read_data_valid,
  output logic [DATA_W-1:0]   m0_read_data,
  input  logic                m1_burstbegin,
  input  logic                m1_write_req,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [2:0]          m1_size,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_be,
  output logic                m1_ready,
  input  logic                avl_ready,
  output logic                avl_burstbegin,
  output logic                avl_read_req,
  output logic                avl_write_req,
  output logic [ADDR_W-1:0]   avl_addr,
  output logic [2:0]          avl_size,
  output logic [DATA_W-1:0]   avl_wdata,
  output logic [DATA_W/8-1:0] avl_be,
  input  logic                avl_read_data_valid,
  input  logic [DATA_W-1:0]   avl_read_data,
  output logic [7:0]          rd_outstanding
);

  typedef enum logic [1:0] {IDLE, GRANT_RD, GRANT_WR} state_t;

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  state_t              state, state_nx;
  logic [2:0]          wr_cnt;
  logic                wr_started;
  logic [STARVE_W-1:0] starve_cnt;
  logic                pick_wr;
  logic                grant_rd, grant_wr;
  logic                rd_accept, wr_accept, wr_last;
  logic [2:0]          rd_size_eff, wr_size_eff;
  logic [8:0]          rd_sum, rd_next;

  assign m0_read_data_valid = avl_read_data_valid;
  assign m0_read_data       = avl_read_data;

  assign rd_size_eff = (m0_size == 3'd0) ? 3'd1 : m0_size;
  assign wr_size_eff = (m1_size == 3'd0) ? 3'd1 : m1_size;
  assign rd_accept   = (state == GRANT_RD) && avl_ready && m0_read_req;
  assign wr_accept   = (state == GRANT_WR) && avl_ready && m1_write_req;
  assign wr_last     = wr_started ? (wr_cnt == 3'd1) : (wr_size_eff == 3'd1);

`ifdef DDR3_ARB_RD_PRIORITY_EN
  assign pick_wr = (starve_cnt >= STARVE_W'(STARVE_LIMIT));
`else
  logic rr_wr_next;

  assign pick_wr = rr_wr_next;

  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n)  rr_wr_next <= 1'b0;
    else if (grant_rd)  rr_wr_next <= 1'b1;
    else if (grant_wr)  rr_wr_next <= 1'b0;
  end
`endif

  always_comb begin
    state_nx       = state;
    grant_rd       = 1'b0;
    grant_wr       = 1'b0;
    m0_ready       = 1'b0;
    m1_ready       = 1'b0;
    avl_burstbegin = 1'b0;
    avl_read_req   = 1'b0;
    avl_write_req  = 1'b0;
    avl_addr       = '0;
    avl_size       = '0;
    avl_wdata      = '0;
    avl_be         = '0;
    case (state)
      IDLE: begin
        if (m0_read_req && m1_write_req) begin
          grant_wr = pick_wr;
          grant_rd = !pick_wr;
        end else begin
          grant_rd = m0_read_req;
          grant_wr = m1_write_req;
        end
        if (grant_rd)      state_nx = GRANT_RD;
        else if (grant_wr) state_nx = GRANT_WR;
      end
      GRANT_RD: begin
        avl_burstbegin = m0_burstbegin;
        avl_read_req   = m0_read_req;
        avl_addr       = m0_addr;
        avl_size       = m0_size;
        m0_ready       = avl_ready;
        if (rd_accept) state_nx = IDLE;
      end
      GRANT_WR: begin
        avl_burstbegin = m1_burstbegin;
        avl_write_req  = m1_write_req;
        avl_addr       = m1_addr;
        avl_size       = m1_size;
        avl_wdata      = m1_wdata;
        avl_be         = m1_be;
        m1_ready       = avl_ready;
        if (wr_accept && wr_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) state <= IDLE;
    else               state <= state_nx;
  end

  // wr_cnt holds beats still owed after the last accepted one
  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) begin
      wr_cnt     <= 3'd0;
      wr_started <= 1'b0;
    end else if (wr_accept) begin
      wr_cnt     <= wr_started ? wr_cnt - 3'd1 : wr_size_eff - 3'd1;
      wr_started <= !wr_last;
    end
  end

  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n)
      starve_cnt <= '0;
    else if (grant_wr)
      starve_cnt <= '0;
    else if (grant_rd && m1_write_req && (starve_cnt != STARVE_W'(STARVE_LIMIT)))
      starve_cnt <= starve_cnt + 1'b1;
  end

  always_comb begin
    rd_sum  = {1'b0, rd_outstanding} + (rd_accept ? {6'd0, rd_size_eff} : 9'd0);
    rd_next = (avl_read_data_valid && (rd_sum != 9'd0)) ? rd_sum - 9'd1 : rd_sum;
    if (rd_next > 9'd255) rd_next = 9'd255;
  end

  always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
    if (!ddr3_reset_n) rd_outstanding <= 8'd0;
    else               rd_outstanding <= rd_next[7:0];
  end

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// tb/tb_ddr3_avl_arbiter.sv - self-checking bench for ddr3_avl_arbiter
// Table-driven cycle vectors plus hand-written contention, overlap, saturation and reset sequences.
module tb_ddr3_avl_arbiter;

  localparam int          ADDR_W = 26;
  localparam int          DATA_W = 128;
  localparam logic [25:0] RA     = 26'h100;
  localparam logic [25:0] WA     = 26'h2000;
  localparam logic [127:0] WD    = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;

  logic                ddr3_clk = 1'b0;
  logic                ddr3_reset_n;
  logic                m0_burstbegin, m0_read_req, m0_ready, m0_read_data_valid;
  logic [ADDR_W-1:0]   m0_addr;
  logic [2:0]          m0_size;
  logic [DATA_W-1:0]   m0_read_data;
  logic                m1_burstbegin, m1_write_req, m1_ready;
  logic [ADDR_W-1:0]   m1_addr;
  logic [2:0]          m1_size;
  logic [DATA_W-1:0]   m1_wdata;
  logic [DATA_W/8-1:0] m1_be;
  logic                avl_ready, avl_burstbegin, avl_read_req, avl_write_req;
  logic [ADDR_W-1:0]   avl_addr;
  logic [2:0]          avl_size;
  logic [DATA_W-1:0]   avl_wdata;
  logic [DATA_W/8-1:0] avl_be;
  logic                avl_read_data_valid;
  logic [DATA_W-1:0]   avl_read_data;
  logic [7:0]          rd_outstanding;

  int checks = 0;
  int errors = 0;

  ddr3_avl_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(16)) dut (
    .ddr3_clk(ddr3_clk), .ddr3_reset_n(ddr3_reset_n),
    .m0_burstbegin(m0_burstbegin), .m0_read_req(m0_read_req), .m0_addr(m0_addr),
    .m0_size(m0_size), .m0_ready(m0_ready), .m0_read_data_valid(m0_read_data_valid),
    .m0_read_data(m0_read_data),
    .m1_burstbegin(m1_burstbegin), .m1_write_req(m1_write_req), .m1_addr(m1_addr),
    .m1_size(m1_size), .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_ready(m1_ready),
    .avl_ready(avl_ready), .avl_burstbegin(avl_burstbegin), .avl_read_req(avl_read_req),
    .avl_write_req(avl_write_req), .avl_addr(avl_addr), .avl_size(avl_size),
    .avl_wdata(avl_wdata), .avl_be(avl_be), .avl_read_data_valid(avl_read_data_valid),
    .avl_read_data(avl_read_data), .rd_outstanding(rd_outstanding)
  );

  always #5 ddr3_clk = ~ddr3_clk;

  typedef struct {
    logic       m0r; logic [2:0] m0s;
    logic       m1r; logic m1b; logic [2:0] m1s;
    logic       rdy; logic rdv;
    logic       e_rd; logic e_wr; logic e_m0r; logic e_m1r; logic e_bb;
    logic [25:0] e_addr; logic [2:0] e_size; logic [7:0] e_out;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(int m0r, int m0s, int m1r, int m1b, int m1s, int rdy, int rdv,
                              int e_rd, int e_wr, int e_m0r, int e_m1r, int e_bb,
                              logic [25:0] e_addr, int e_size, int e_out);
    vec_t v;
    v.m0r = 1'(m0r); v.m0s = 3'(m0s); v.m1r = 1'(m1r); v.m1b = 1'(m1b); v.m1s = 3'(m1s);
    v.rdy = 1'(rdy); v.rdv = 1'(rdv);
    v.e_rd = 1'(e_rd); v.e_wr = 1'(e_wr); v.e_m0r = 1'(e_m0r); v.e_m1r = 1'(e_m1r);
    v.e_bb = 1'(e_bb); v.e_addr = e_addr; v.e_size = 3'(e_size); v.e_out = 8'(e_out);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic m0r, input logic [2:0] m0s, input logic m1r, input logic m1b,
                       input logic [2:0] m1s, input logic rdy, input logic rdv);
    m0_read_req = m0r; m0_burstbegin = m0r; m0_size = m0s;
    m1_write_req = m1r; m1_burstbegin = m1b; m1_size = m1s;
    avl_ready = rdy; avl_read_data_valid = rdv;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " rd_req"}, 128'(avl_read_req), 128'd0);
    chk({nm, " wr_req"}, 128'(avl_write_req), 128'd0);
    chk({nm, " readies"}, 128'({m0_ready, m1_ready}), 128'd0);
    chk({nm, " addr"}, 128'(avl_addr), 128'd0);
  endtask

  task automatic do_reset();
    @(negedge ddr3_clk);
    ddr3_reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge ddr3_clk);
    @(negedge ddr3_clk);
    ddr3_reset_n = 1'b1;
  endtask

  initial begin
    int beats;
    logic [1:0] exp_g;

    m0_addr = RA; m1_addr = WA; m1_wdata = WD; m1_be = '1; avl_read_data = '0;
    drive(0, 0, 0, 0, 0, 0, 0);
    ddr3_reset_n = 1'b0;
    #2;
    chk_idle("reset");
    chk("reset bb", 128'(avl_burstbegin), 128'd0);
    chk("reset out", 128'(rd_outstanding), 128'd0);
    @(negedge ddr3_clk);
    ddr3_reset_n = 1'b1;

    vecs[0]  = mk(1,4,0,0,0,0,0, 0,0,0,0,0,26'h0,0,0);
    vecs[1]  = mk(1,4,0,0,0,0,0, 1,0,0,0,1,RA,4,0);
    vecs[2]  = mk(1,4,0,0,0,0,0, 1,0,0,0,1,RA,4,0);
    vecs[3]  = mk(1,4,0,0,0,1,0, 1,0,1,0,1,RA,4,0);
    vecs[4]  = mk(0,4,0,0,0,1,0, 0,0,0,0,0,26'h0,0,4);
    vecs[5]  = mk(0,0,0,0,0,1,1, 0,0,0,0,0,26'h0,0,4);
    vecs[6]  = mk(0,0,0,0,0,1,1, 0,0,0,0,0,26'h0,0,3);
    vecs[7]  = mk(0,0,0,0,0,1,1, 0,0,0,0,0,26'h0,0,2);
    vecs[8]  = mk(0,0,0,0,0,1,1, 0,0,0,0,0,26'h0,0,1);
    vecs[9]  = mk(0,0,0,0,0,1,0, 0,0,0,0,0,26'h0,0,0);
    vecs[10] = mk(0,0,1,1,3,1,0, 0,0,0,0,0,26'h0,0,0);
    vecs[11] = mk(0,0,1,1,3,0,0, 0,1,0,0,1,WA,3,0);
    vecs[12] = mk(0,0,1,1,3,1,0, 0,1,0,1,1,WA,3,0);
    vecs[13] = mk(0,0,1,0,3,0,0, 0,1,0,0,0,WA,3,0);
    vecs[14] = mk(0,0,1,0,3,1,0, 0,1,0,1,0,WA,3,0);
    vecs[15] = mk(0,0,1,0,3,1,0, 0,1,0,1,0,WA,3,0);
    vecs[16] = mk(0,0,0,0,0,1,0, 0,0,0,0,0,26'h0,0,0);
    vecs[17] = mk(0,0,0,0,0,1,1, 0,0,0,0,0,26'h0,0,0);
    vecs[18] = mk(0,0,0,0,0,1,0, 0,0,0,0,0,26'h0,0,0);
    vecs[19] = mk(1,0,0,0,0,1,0, 0,0,0,0,0,26'h0,0,0);
    vecs[20] = mk(1,0,0,0,0,1,0, 1,0,1,0,1,RA,0,0);
    vecs[21] = mk(0,0,0,0,0,1,0, 0,0,0,0,0,26'h0,0,1);
    vecs[22] = mk(1,2,0,0,0,1,0, 0,0,0,0,0,26'h0,0,1);
    vecs[23] = mk(1,2,0,0,0,1,1, 1,0,1,0,1,RA,2,1);
    vecs[24] = mk(0,0,0,0,0,1,0, 0,0,0,0,0,26'h0,0,2);

    for (int i = 0; i < 25; i++) begin
      @(negedge ddr3_clk);
      drive(vecs[i].m0r, vecs[i].m0s, vecs[i].m1r, vecs[i].m1b, vecs[i].m1s, vecs[i].rdy, vecs[i].rdv);
      #1;
      chk($sformatf("v%0d rd_req", i), 128'(avl_read_req), 128'(vecs[i].e_rd));
      chk($sformatf("v%0d wr_req", i), 128'(avl_write_req), 128'(vecs[i].e_wr));
      chk($sformatf("v%0d m0_ready", i), 128'(m0_ready), 128'(vecs[i].e_m0r));
      chk($sformatf("v%0d m1_ready", i), 128'(m1_ready), 128'(vecs[i].e_m1r));
      chk($sformatf("v%0d burstbegin", i), 128'(avl_burstbegin), 128'(vecs[i].e_bb));
      chk($sformatf("v%0d addr", i), 128'(avl_addr), 128'(vecs[i].e_addr));
      chk($sformatf("v%0d size", i), 128'(avl_size), 128'(vecs[i].e_size));
      chk($sformatf("v%0d wdata", i), avl_wdata, vecs[i].e_wr ? WD : 128'd0);
      chk($sformatf("v%0d be", i), 128'(avl_be), vecs[i].e_wr ? 128'hFFFF : 128'd0);
      chk($sformatf("v%0d rd_outstanding", i), 128'(rd_outstanding), 128'(vecs[i].e_out));
    end

    // saturation: 40 reads of 7 beats with no returns
    for (int i = 0; i < 40; i++) begin
      @(negedge ddr3_clk); drive(1, 7, 0, 0, 0, 1, 0);
      @(negedge ddr3_clk); drive(1, 7, 0, 0, 0, 1, 0);
    end
    @(negedge ddr3_clk); drive(0, 0, 0, 0, 0, 1, 1);
    #1 chk("sat 255", 128'(rd_outstanding), 128'd255);
    @(negedge ddr3_clk); drive(0, 0, 0, 0, 0, 1, 0);
    #1 chk("sat dec", 128'(rd_outstanding), 128'd254);

    do_reset();
`ifdef DDR3_ARB_RD_PRIORITY_EN
    for (int c = 0; c < 36; c++) begin
      @(negedge ddr3_clk);
      drive(1, 1, 1, 1, 1, 1, 0);
      #1;
      if (c % 2 == 0)      exp_g = 2'b00;
      else if (c == 33)    exp_g = 2'b01;
      else                 exp_g = 2'b10;
      chk($sformatf("prio c%0d grant", c), 128'({avl_read_req, avl_write_req}), 128'(exp_g));
    end
`else
    for (int c = 0; c < 8; c++) begin
      @(negedge ddr3_clk);
      drive(1, 1, 1, 1, 1, 1, 0);
      #1;
      exp_g = (c % 4 == 1) ? 2'b10 : (c % 4 == 3) ? 2'b01 : 2'b00;
      chk($sformatf("rr c%0d grant", c), 128'({avl_read_req, avl_write_req}), 128'(exp_g));
    end
`endif

    // overlap: 4 read returns during a 4-beat write
    do_reset();
    @(negedge ddr3_clk); drive(1, 4, 0, 0, 0, 1, 0);
    @(negedge ddr3_clk); drive(1, 4, 0, 0, 0, 1, 0);
    @(negedge ddr3_clk); drive(0, 0, 1, 1, 4, 1, 0);
    #1 chk("ovl out4", 128'(rd_outstanding), 128'd4);
    beats = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ddr3_clk);
      drive(0, 0, 1, (i == 0), 4, 1, 1);
      avl_read_data = 128'(32'hA0 + i);
      #1;
      if (m1_ready) beats++;
      chk($sformatf("ovl b%0d rdv", i), 128'(m0_read_data_valid), 128'd1);
      chk($sformatf("ovl b%0d rdata", i), m0_read_data, 128'(32'hA0 + i));
      chk($sformatf("ovl b%0d wr_req", i), 128'(avl_write_req), 128'd1);
    end
    @(negedge ddr3_clk); drive(0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("ovl beats", 128'(beats), 128'd4);
    chk("ovl out0", 128'(rd_outstanding), 128'd0);
    chk_idle("ovl end");

    // reset mid-write after beat 1 of 4
    @(negedge ddr3_clk); drive(1, 2, 0, 0, 0, 1, 0);
    @(negedge ddr3_clk); drive(1, 2, 0, 0, 0, 1, 0);
    @(negedge ddr3_clk); drive(0, 0, 1, 1, 4, 1, 0);
    @(negedge ddr3_clk); drive(0, 0, 1, 1, 4, 1, 0);
    @(negedge ddr3_clk); drive(0, 0, 1, 0, 4, 1, 0);
    #1 chk("mid wr_req", 128'(avl_write_req), 128'd1);
    chk("mid out", 128'(rd_outstanding), 128'd2);
    #1 ddr3_reset_n = 1'b0;
    #1;
    chk_idle("async rst");
    chk("async rst out", 128'(rd_outstanding), 128'd0);
    @(negedge ddr3_clk); drive(0, 0, 0, 0, 0, 1, 0);
    @(negedge ddr3_clk); ddr3_reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ddr3_clk);
      #1 chk_idle($sformatf("post rst %0d", i));
    end
    @(negedge ddr3_clk); drive(0, 0, 1, 1, 4, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge ddr3_clk); drive(0, 0, 1, (i == 0), 4, 1, 0);
      #1 chk($sformatf("new wr b%0d", i), 128'({avl_write_req, m1_ready}), 128'd3);
    end
    @(negedge ddr3_clk); drive(0, 0, 1, 1, 4, 1, 0);
    #1 chk("new wr done", 128'(avl_write_req), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
